// File: rtl/ysyx_22050243_defs.sv
// Shared constants and types for the JALR redirect slice.
package ysyx_22050243_defs;

    localparam logic [6:0] JALR_OPCODE = 7'b1100111;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB = 2'b10;
    localparam logic [1:0] FWD_RF_ALT = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRedir
    } jalr_state_e;

endpackage

// File: rtl/ysyx_22050243_jalr_target.sv
// JALR target computation: rs1 + sext(imm12), bit0 cleared, plus 4-byte misalign flag.
module ysyx_22050243_jalr_target #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] operand,
    input  logic [11:0]     imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] sum;

    assign imm_sext   = {{(XLEN-12){imm[11]}}, imm};
    // Carry out of the top bit is dropped: the target wraps modulo 2^XLEN.
    assign sum        = operand + imm_sext;
    assign target     = sum & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign misaligned = target[1];

endmodule

// File: rtl/ysyx_22050243_jalr_redirect.sv
// Resolves JALR in ID: waits for rs1, computes target, then holds a redirect until IF accepts it.
module ysyx_22050243_jalr_redirect
    import ysyx_22050243_defs::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned IBUS_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [IBUS_DATA_WIDTH-1:0] inst_if_2_id_ff,
    input  logic [XLEN-1:0]            pc_if_2_id_ff,
    input  logic                       stall_jalr,
    input  logic [1:0]                 fwd_jalr,
    input  logic [XLEN-1:0]            rs1_rdata,
    input  logic [XLEN-1:0]            ex_mem_result,
    input  logic [XLEN-1:0]            mem_wb_result,
    input  logic                       id_kill,
    output logic                       redir_valid,
    output logic [XLEN-1:0]            redir_pc,
    input  logic                       redir_ready,
    output logic                       hold_id,
    output logic                       flush_if_id,
    output logic                       link_valid,
    output logic [XLEN-1:0]            link_data,
    output logic                       misalign_exc,
    output logic [XLEN-1:0]            misalign_tval,
    output logic [31:0]                jalr_stall_cnt
);

    jalr_state_e     state;
    logic [6:0]      opcode;
    logic [4:0]      rs1_idx;
    logic [11:0]     imm;
    logic            jalr_hit;
    logic            evaluate;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            unused_inst;

    assign opcode      = inst_if_2_id_ff[6:0];
    assign rs1_idx     = inst_if_2_id_ff[19:15];
    assign imm         = inst_if_2_id_ff[31:20];
    assign unused_inst = ^inst_if_2_id_ff[14:7];

    assign jalr_hit = id_valid && (opcode == JALR_OPCODE) && !id_kill;
    assign evaluate = ((state == StIdle) && jalr_hit && !stall_jalr) ||
                      ((state == StWait) && !id_kill && !stall_jalr);

    always_comb begin
        operand = rs1_rdata;
        unique case (fwd_jalr)
            FWD_EX_MEM: operand = ex_mem_result;
            FWD_MEM_WB: operand = mem_wb_result;
            FWD_RF, FWD_RF_ALT: operand = rs1_rdata;
            default: operand = rs1_rdata;
        endcase
        // x0 always reads as zero regardless of any forwarding path.
        if (rs1_idx == 5'd0) begin
            operand = '0;
        end
    end

    ysyx_22050243_jalr_target #(
        .XLEN(XLEN)
    ) u_target (
        .operand   (operand),
        .imm       (imm),
        .target    (target),
        .misaligned(misaligned)
    );

    // The IDLE cycle that detects a JALR must already freeze ID, so this one is combinational.
    assign hold_id = (state != StIdle) || jalr_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            redir_valid    <= 1'b0;
            redir_pc       <= '0;
            flush_if_id    <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            misalign_exc   <= 1'b0;
            misalign_tval  <= '0;
            jalr_stall_cnt <= '0;
        end else begin
            misalign_exc <= 1'b0;
            link_valid   <= 1'b0;
            flush_if_id  <= 1'b0;

            if ((state == StWait) && (jalr_stall_cnt != '1)) begin
                jalr_stall_cnt <= jalr_stall_cnt + 32'd1;
            end

            unique case (state)
                StIdle: begin
                    if (jalr_hit && stall_jalr) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (id_kill) begin
                        state <= StIdle;
                    end
                end
                StRedir: begin
                    // Kill takes priority over a same-cycle handshake.
                    if (id_kill) begin
                        state       <= StIdle;
                        redir_valid <= 1'b0;
                    end else if (redir_ready) begin
                        state       <= StIdle;
                        redir_valid <= 1'b0;
                        link_valid  <= 1'b1;
                        flush_if_id <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (evaluate) begin
                if (misaligned) begin
                    misalign_exc  <= 1'b1;
                    misalign_tval <= target;
                    state         <= StIdle;
                end else begin
                    redir_pc    <= target;
                    link_data   <= pc_if_2_id_ff + XLEN'(4);
                    redir_valid <= 1'b1;
                    state       <= StRedir;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_jalr_redirect.sv
// Self-checking bench: directed scenarios plus randomized JALR transactions against an arithmetic model.
module tb_ysyx_22050243_jalr_redirect;

    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [63:0] pc = '0;
    logic        stall_jalr = 1'b0;
    logic [1:0]  fwd_jalr = '0;
    logic [63:0] rs1_rdata = '0;
    logic [63:0] ex_mem_result = '0;
    logic [63:0] mem_wb_result = '0;
    logic        id_kill = 1'b0;
    logic        redir_ready = 1'b0;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        hold_id;
    logic        flush_if_id;
    logic        link_valid;
    logic [63:0] link_data;
    logic        misalign_exc;
    logic [63:0] misalign_tval;
    logic [31:0] jalr_stall_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt = '0;

    ysyx_22050243_jalr_redirect #(
        .XLEN(64),
        .IBUS_DATA_WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .inst_if_2_id_ff(inst),
        .pc_if_2_id_ff  (pc),
        .stall_jalr     (stall_jalr),
        .fwd_jalr       (fwd_jalr),
        .rs1_rdata      (rs1_rdata),
        .ex_mem_result  (ex_mem_result),
        .mem_wb_result  (mem_wb_result),
        .id_kill        (id_kill),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .redir_ready    (redir_ready),
        .hold_id        (hold_id),
        .flush_if_id    (flush_if_id),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .misalign_exc   (misalign_exc),
        .misalign_tval  (misalign_tval),
        .jalr_stall_cnt (jalr_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic garbage_operands();
        fwd_jalr      = 2'($urandom);
        rs1_rdata     = {$urandom, $urandom};
        ex_mem_result = {$urandom, $urandom};
        mem_wb_result = {$urandom, $urandom};
    endtask

    // k: stall cycles before rs1 is ready, d: cycles of redir_ready low,
    // kill_mode: 0 none, 1 kill in WAIT (needs k>0), 2 kill together with redir_ready.
    task automatic run_jalr(input logic [4:0] rs1, input logic [1:0] fwd, input logic [63:0] rf,
                            input logic [63:0] ex, input logic [63:0] wb, input logic [11:0] imm,
                            input logic [63:0] pcv, input int k, input int d, input int kill_mode);
        logic [63:0] op;
        logic [63:0] tgt;
        logic        killed;
        if (rs1 == 5'd0) op = 64'd0;
        else if (fwd == 2'b01) op = ex;
        else if (fwd == 2'b10) op = wb;
        else op = rf;
        tgt = (op + {{52{imm[11]}}, imm}) & ~64'h1;

        id_valid    = 1'b1;
        inst        = {imm, rs1, 3'b000, 5'd1, JALR};
        pc          = pcv;
        id_kill     = 1'b0;
        redir_ready = 1'b0;
        stall_jalr  = (k > 0);
        if (k > 0) garbage_operands();
        else begin
            fwd_jalr = fwd; rs1_rdata = rf; ex_mem_result = ex; mem_wb_result = wb;
        end
        #1 check("hold_detect", hold_id, 1'b1);

        if (k > 0) begin
            tick();
            check("wait_no_redir", redir_valid, 1'b0);
            if (kill_mode == 1) begin
                id_kill = 1'b1;
                tick();
                exp_cnt = exp_cnt + 32'd1;
                check("kill_wait_redir", redir_valid, 1'b0);
                check("kill_wait_misalign", misalign_exc, 1'b0);
                check("kill_wait_cnt", jalr_stall_cnt, exp_cnt);
                id_kill  = 1'b0;
                id_valid = 1'b0;
                stall_jalr = 1'b0;
                tick();
                check("kill_wait_idle", redir_valid, 1'b0);
                return;
            end
            for (int i = 1; i < k; i++) begin
                garbage_operands();
                tick();
                check("wait_hold", hold_id, 1'b1);
            end
            stall_jalr = 1'b0;
            fwd_jalr = fwd; rs1_rdata = rf; ex_mem_result = ex; mem_wb_result = wb;
            exp_cnt = exp_cnt + 32'(k);
        end

        tick();
        check("stall_cnt", jalr_stall_cnt, exp_cnt);
        if (tgt[1]) begin
            check("misalign_pulse", misalign_exc, 1'b1);
            check("misalign_tval", misalign_tval, tgt);
            check("misalign_no_redir", redir_valid, 1'b0);
            id_valid = 1'b0;
            tick();
            check("misalign_drop", misalign_exc, 1'b0);
            check("misalign_idle_redir", redir_valid, 1'b0);
            return;
        end

        check("redir_valid", redir_valid, 1'b1);
        check("redir_pc", redir_pc, tgt);
        check("redir_hold", hold_id, 1'b1);
        check("redir_no_link", link_valid, 1'b0);
        for (int j = 0; j < d; j++) begin
            stall_jalr = 1'($urandom);
            tick();
            check("bp_valid", redir_valid, 1'b1);
            check("bp_pc", redir_pc, tgt);
            check("bp_hold", hold_id, 1'b1);
            check("bp_no_flush", flush_if_id, 1'b0);
        end
        stall_jalr  = 1'b0;
        killed      = (kill_mode == 2);
        redir_ready = 1'b1;
        id_kill     = killed;
        tick();
        redir_ready = 1'b0;
        id_kill     = 1'b0;
        check("hs_valid_drop", redir_valid, 1'b0);
        check("hs_link_valid", link_valid, !killed);
        check("hs_flush", flush_if_id, !killed);
        if (!killed) check("hs_link_data", link_data, pcv + 64'd4);
        id_valid = 1'b0;
        tick();
        check("hs_link_pulse", link_valid, 1'b0);
        check("hs_flush_pulse", flush_if_id, 1'b0);
        check("hs_idle_redir", redir_valid, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_redir_valid", redir_valid, 1'b0);
        check("rst_redir_pc", redir_pc, 64'd0);
        check("rst_link", {link_valid, flush_if_id, misalign_exc, hold_id}, 4'b0);
        check("rst_cnt", jalr_stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Non-JALR and invalid slots produce nothing.
        id_valid = 1'b1;
        inst = {12'h010, 5'd5, 3'b000, 5'd1, 7'b1101111};
        rs1_rdata = 64'h8000_0000;
        #1 check("nonjalr_hold", hold_id, 1'b0);
        tick();
        check("nonjalr_redir", redir_valid, 1'b0);
        check("nonjalr_misalign", misalign_exc, 1'b0);
        id_valid = 1'b0;
        inst = {12'h010, 5'd5, 3'b000, 5'd1, JALR};
        #1 check("invalid_hold", hold_id, 1'b0);
        tick();
        check("invalid_redir", redir_valid, 1'b0);

        // No hazard, immediate accept.
        run_jalr(5'd5, 2'b00, 64'h8000_0000, 64'h0, 64'h0, 12'h010, 64'h8000_0100, 0, 0, 0);
        // Load-use: three stall cycles then MEM/WB forward.
        run_jalr(5'd5, 2'b10, 64'h1234, 64'h5678, 64'h8000_1001, 12'h000, 64'h8000_0200, 3, 0, 0);
        // Misaligned target.
        run_jalr(5'd6, 2'b00, 64'h8000_0002, 64'h0, 64'h0, 12'h000, 64'h8000_0300, 0, 0, 0);
        // Backpressure then kill racing the handshake.
        run_jalr(5'd7, 2'b01, 64'h0, 64'h8000_4000, 64'h0, 12'hFF8, 64'h8000_0400, 0, 4, 2);
        // Kill while waiting for rs1.
        run_jalr(5'd7, 2'b00, 64'h8000_4000, 64'h0, 64'h0, 12'h004, 64'h8000_0500, 2, 0, 1);
        // Wrap-around target, rs1 = x0 with forwarding ignored.
        run_jalr(5'd8, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 12'h002, 64'h8000_0600, 0, 1, 0);
        run_jalr(5'd0, 2'b01, 64'h0, 64'hDEAD_BEEF, 64'h0, 12'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int km;
            int kk;
            kk = int'($urandom_range(0, 3));
            km = int'($urandom_range(0, 4));
            if (km > 2) km = 0;
            if (km == 1 && kk == 0) km = 0;
            run_jalr(5'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 12'($urandom), {$urandom, $urandom} & ~64'h3,
                     kk, int'($urandom_range(0, 4)), km);
        end

        // Asynchronous reset in the middle of a redirect.
        id_valid = 1'b1;
        inst = {12'h020, 5'd5, 3'b000, 5'd1, JALR};
        pc = 64'h8000_0700;
        fwd_jalr = 2'b00;
        rs1_rdata = 64'h8000_0000;
        stall_jalr = 1'b0;
        redir_ready = 1'b0;
        tick();
        check("pre_rst_redir", redir_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_redir", redir_valid, 1'b0);
        check("async_rst_pc", redir_pc, 64'd0);
        check("async_rst_link", link_data, 64'd0);
        check("async_rst_tval", misalign_tval, 64'd0);
        check("async_rst_cnt", jalr_stall_cnt, 32'd0);
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", redir_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
